// File: rtl/pwm_pkg.sv
// Shared constants for the PWM output peripheral: counter width, full-duty code
// and the default prescale ratio.
package pwm_pkg;

   localparam int PWM_CNT_W = 8;
   localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
   localparam int DEFAULT_CLK_DIV = 13;

   function automatic int div_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler producing one tick every CLK_DIV clocks, the 8-bit
// period counter, and a registered pulse on the first clock of each period.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 tick,
   output logic [PWM_CNT_W-1:0] pwm_cnt,
   output logic                 wrap,
   output logic                 period_start
);

   localparam int DIV_W = div_width(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
   localparam logic [PWM_CNT_W-1:0] CNT_ONE = PWM_CNT_W'(1);
   localparam logic [PWM_CNT_W-1:0] CNT_LAST = {PWM_CNT_W{1'b1}};

   logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
   logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                 period_start_q, period_start_d;

   always_comb begin
      tick           = (div_cnt_q == DIV_LAST);
      wrap           = tick && (pwm_cnt_q == CNT_LAST);
      div_cnt_d      = tick ? '0 : div_cnt_q + DIV_ONE;
      pwm_cnt_d      = tick ? pwm_cnt_q + CNT_ONE : pwm_cnt_q;
      period_start_d = wrap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q      <= '0;
         pwm_cnt_q      <= '0;
         period_start_q <= 1'b0;
      end else begin
         div_cnt_q      <= div_cnt_d;
         pwm_cnt_q      <= pwm_cnt_d;
         period_start_q <= period_start_d;
      end
   end

   assign pwm_cnt      = pwm_cnt_q;
   assign period_start = period_start_q;

endmodule

// File: rtl/pwm_peripheral.sv
// PWM output peripheral: drives 16 pins low, static high, or from a shared 8-bit
// PWM waveform whose duty is shadowed and only updated at period boundaries.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   logic [15:0]          en_out;
   logic [15:0]          en_pwm;
   logic [PWM_CNT_W-1:0] pwm_cnt;
   logic                 wrap;
   // The duty shadow loads on wrap, which already qualifies tick.
   logic                 tick_unused;
   logic [7:0]           duty_sh_q, duty_sh_d;
   logic                 pwm_hi;
   logic [15:0]          out_q, out_d;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   pwm_timebase #(
      .CLK_DIV (CLK_DIV)
   ) u_timebase (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick_unused),
      .pwm_cnt      (pwm_cnt),
      .wrap         (wrap),
      .period_start (period_start)
   );

   always_comb begin
      duty_sh_d = wrap ? pwm_duty_cycle : duty_sh_q;
      // Full code is forced high so the last count of the period has no gap.
      pwm_hi    = (duty_sh_q == DUTY_FULL) || (pwm_cnt < duty_sh_q);
      out_d     = '0;
      for (int i = 0; i < 16; i++) begin
         out_d[i] = en_out[i] && (!en_pwm[i] || pwm_hi);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_sh_q <= '0;
         out_q     <= '0;
      end else begin
         duty_sh_q <= duty_sh_d;
         out_q     <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral (CLK_DIV=4 main instance, CLK_DIV=1 side instance).
module tb_pwm_peripheral;

   localparam int D = 4;
   localparam int P = 256 * D;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] en_out = '0;
   logic [15:0] en_pwm = '0;
   logic [7:0]  duty = '0;
   logic [15:0] out, out1;
   logic        period_start, ps1;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pwm_peripheral #(.CLK_DIV(D)) dut (
      .clk(clk), .rst(rst),
      .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
      .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
      .pwm_duty_cycle(duty), .out(out), .period_start(period_start));

   pwm_peripheral #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst),
      .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
      .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
      .pwm_duty_cycle(duty), .out(out1), .period_start(ps1));

   // Reference model: everything derives from m_c, the number of rising edges
   // since reset release. Tick k lands on edge k*D, so the period count seen
   // before edge c is (c/D) mod 256 and a new period begins on every edge c
   // that is a multiple of P, where the duty input is sampled.
   int          m_c;
   logic [7:0]  m_duty;
   logic [15:0] m_out;
   logic        m_ps;

   always @(posedge clk or posedge rst) begin : model
      int   cnt;
      logic level;
      if (rst) begin
         m_c    = 0;
         m_duty = '0;
         m_out  = '0;
         m_ps   = 1'b0;
      end else begin
         cnt   = (m_c / D) % 256;
         level = (m_duty == 8'hFF) || (cnt < int'(m_duty));
         for (int i = 0; i < 16; i++)
            m_out[i] = en_out[i] ? (en_pwm[i] ? level : 1'b1) : 1'b0;
         m_c  = m_c + 1;
         m_ps = ((m_c % P) == 0);
         if (m_ps) m_duty = duty;
      end
   end

   // Holds reset for two clocks and returns on the releasing falling edge.
   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      en_out = 16'hFFFF;
      en_pwm = 16'h0000;
      duty   = 8'hFF;
      rst    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got=%h want=0000", out); end
      n_checks++;
      if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_ps got=%b want=0", period_start); end
      n_checks++;
      if (out1 !== 16'h0000) begin n_fail++; $display("FAIL reset_out_div1 got=%h want=0000", out1); end
      n_checks++;
      if (ps1 !== 1'b0) begin n_fail++; $display("FAIL reset_ps_div1 got=%b want=0", ps1); end
      rst = 1'b0;
   endtask

   task automatic test_static;
      @(negedge clk);
      n_checks++;
      if (out !== 16'hFFFF) begin n_fail++; $display("FAIL static_high got=%h want=ffff", out); end
      for (int k = 0; k < 40; k++) begin
         en_out = 16'($urandom);
         en_pwm = 16'($urandom);
         @(negedge clk);
         n_checks++;
         if (out !== m_out || period_start !== m_ps) begin
            n_fail++;
            $display("FAIL static_model c=%0d got=%h/%b want=%h/%b", m_c, out, period_start, m_out, m_ps);
         end
      end
      en_out = 16'hFFFF;
      en_pwm = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (out !== 16'h0000 || period_start !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got=%h/%b want=0000/0", out, period_start);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_gating;
      int hi2, hi1, masked, shape;
      en_out = 16'h00F0;
      en_pwm = 16'hFFFF;
      duty   = 8'h80;
      do_reset();
      hi1 = 0; hi2 = 0; masked = 0; shape = 0;
      repeat (3 * P) begin
         @(negedge clk);
         n_checks++;
         if (out !== m_out || period_start !== m_ps) begin
            n_fail++;
            $display("FAIL gating_model c=%0d got=%h/%b want=%h/%b", m_c, out, period_start, m_out, m_ps);
         end
         if ((out & 16'hFF0F) != 16'h0000) masked++;
         if (m_c <= P && out[4]) hi1++;
         if (m_c > P && m_c <= 2 * P) begin
            if (out[4]) hi2++;
            if (m_c <= P + 512 && out[7:4] != 4'hF) shape++;
            if (m_c > P + 512 && out[7:4] != 4'h0) shape++;
         end
      end
      n_checks++;
      if (masked != 0) begin n_fail++; $display("FAIL gating_masked got=%0d want=0", masked); end
      n_checks++;
      if (hi1 != 0) begin n_fail++; $display("FAIL gating_first_period got=%0d want=0", hi1); end
      n_checks++;
      if (hi2 != 512) begin n_fail++; $display("FAIL gating_high_clocks got=%0d want=512", hi2); end
      n_checks++;
      if (shape != 0) begin n_fail++; $display("FAIL gating_shape got=%0d want=0", shape); end
   endtask

   task automatic test_endpoints;
      int hi2, lo3;
      logic last_hi;
      en_out = 16'hFFFF;
      en_pwm = 16'hFFFF;
      duty   = 8'h00;
      do_reset();
      hi2 = 0; lo3 = 0; last_hi = 1'b0;
      repeat (3 * P) begin
         @(negedge clk);
         n_checks++;
         if (out !== m_out || period_start !== m_ps) begin
            n_fail++;
            $display("FAIL endpoint_model c=%0d got=%h/%b want=%h/%b", m_c, out, period_start, m_out, m_ps);
         end
         if (m_c > P && m_c <= 2 * P && out != 16'h0000) hi2++;
         if (m_c > 2 * P && out != 16'hFFFF) lo3++;
         if (m_c == 3 * P) last_hi = out[0];
         if (m_c == P + 10) duty = 8'hFF;
      end
      n_checks++;
      if (hi2 != 0) begin n_fail++; $display("FAIL duty00_high_clocks got=%0d want=0", hi2); end
      n_checks++;
      if (lo3 != 0) begin n_fail++; $display("FAIL dutyff_low_clocks got=%0d want=0", lo3); end
      n_checks++;
      if (last_hi !== 1'b1) begin n_fail++; $display("FAIL dutyff_cnt255 got=%b want=1", last_hi); end
   endtask

   task automatic test_shadowing;
      int hi2, hi3;
      en_out = 16'hFFFF;
      en_pwm = 16'hFFFF;
      duty   = 8'h40;
      do_reset();
      hi2 = 0; hi3 = 0;
      repeat (3 * P) begin
         @(negedge clk);
         n_checks++;
         if (out !== m_out || period_start !== m_ps) begin
            n_fail++;
            $display("FAIL shadow_model c=%0d got=%h/%b want=%h/%b", m_c, out, period_start, m_out, m_ps);
         end
         if (m_c > P && m_c <= 2 * P && out[9]) hi2++;
         if (m_c > 2 * P && out[9]) hi3++;
         if (m_c == P + 100 * D) duty = 8'hC0;
      end
      n_checks++;
      if (hi2 != 256) begin n_fail++; $display("FAIL shadow_current got=%0d want=256", hi2); end
      n_checks++;
      if (hi3 != 768) begin n_fail++; $display("FAIL shadow_next got=%0d want=768", hi3); end
   endtask

   task automatic test_period_pulse;
      int last_pulse, pulses, rises;
      logic prev_ps, prev_o;
      en_out = 16'hFFFF;
      en_pwm = 16'hFFFF;
      duty   = 8'($urandom_range(1, 254));
      do_reset();
      last_pulse = -1; pulses = 0; rises = 0; prev_ps = 1'b0; prev_o = 1'b0;
      repeat (4 * P + 2) begin
         @(negedge clk);
         n_checks++;
         if (out !== m_out || period_start !== m_ps) begin
            n_fail++;
            $display("FAIL pulse_model c=%0d got=%h/%b want=%h/%b", m_c, out, period_start, m_out, m_ps);
         end
         if (period_start === 1'b1) begin
            n_checks++;
            if (m_c - last_pulse != ((last_pulse < 0) ? P + 1 : P)) begin
               n_fail++;
               $display("FAIL pulse_spacing at=%0d prev=%0d want_gap=%0d", m_c, last_pulse, P);
            end
            n_checks++;
            if (prev_ps === 1'b1) begin n_fail++; $display("FAIL pulse_width at=%0d got=2+ want=1", m_c); end
            if (last_pulse < 0) last_pulse = 0;
            last_pulse = m_c;
            pulses++;
         end
         if (out[0] === 1'b1 && prev_o === 1'b0) begin
            rises++;
            n_checks++;
            if (prev_ps !== 1'b1) begin n_fail++; $display("FAIL pulse_rise_align at=%0d got_ps_prev=%b want=1", m_c, prev_ps); end
         end
         prev_ps = period_start;
         prev_o  = out[0];
      end
      n_checks++;
      if (pulses != 4) begin n_fail++; $display("FAIL pulse_count got=%0d want=4", pulses); end
      n_checks++;
      if (rises != 4) begin n_fail++; $display("FAIL pulse_rises got=%0d want=4", rises); end
   endtask

   task automatic test_clkdiv1;
      int hi2, hi3, ps_err;
      en_out = 16'hFFFF;
      en_pwm = 16'hFFFF;
      duty   = 8'h01;
      do_reset();
      hi2 = 0; hi3 = 0; ps_err = 0;
      repeat (3 * 256) begin
         @(negedge clk);
         if (ps1 !== ((m_c % 256) == 0)) ps_err++;
         if (m_c > 256 && m_c <= 512 && out1[0]) hi2++;
         if (m_c > 512 && out1[0]) hi3++;
      end
      n_checks++;
      if (hi2 != 1) begin n_fail++; $display("FAIL div1_period2_high got=%0d want=1", hi2); end
      n_checks++;
      if (hi3 != 1) begin n_fail++; $display("FAIL div1_period3_high got=%0d want=1", hi3); end
      n_checks++;
      if (ps_err != 0) begin n_fail++; $display("FAIL div1_period_start got_errs=%0d want=0", ps_err); end
   endtask

   task automatic test_random;
      en_out = 16'($urandom);
      en_pwm = 16'($urandom);
      duty   = 8'($urandom);
      do_reset();
      repeat (3 * P + 16) begin
         @(negedge clk);
         n_checks++;
         if (out !== m_out || period_start !== m_ps) begin
            n_fail++;
            $display("FAIL random_model c=%0d got=%h/%b want=%h/%b", m_c, out, period_start, m_out, m_ps);
         end
         if ($urandom_range(0, 7) == 0) begin
            en_out = 16'($urandom);
            en_pwm = 16'($urandom);
         end
         // Duty and enables both change right before the wrap edge.
         if ((m_c % P) == P - 1) begin
            duty   = 8'($urandom);
            en_pwm = 16'($urandom);
         end else if ($urandom_range(0, 63) == 0) begin
            duty = 8'($urandom);
         end
      end
   endtask

   initial begin
      test_reset();
      test_static();
      test_gating();
      test_endpoints();
      test_shadowing();
      test_period_pulse();
      test_clkdiv1();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
